// File: rtl/score_ctrl_pkg.sv
// Shared game definitions: FSM state encodings, screen geometry, default goal lines
// and a saturating score increment.
package score_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Goal lines sit just inside the visible area on each side.
    localparam logic [9:0] GOAL_LX_DEF = 10'd8;
    localparam logic [9:0] GOAL_RX_DEF = 10'(H_ACTIVE - 9);

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/score_ctrl_serve_timer.sv
// Counts frame ticks while serving; done flags the tick that brings the count to
// SERVE_FRAMES.
module serve_timer #(
    parameter logic [7:0] SERVE_FRAMES = 8'd60
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic done
);

    logic [7:0] count;

    assign done = tick && !clr && (count == SERVE_FRAMES - 8'd1);

    always_ff @(posedge clk) begin
        if (!rst)
            count <= 8'd0;
        else if (clr)
            count <= 8'd0;
        else if (tick)
            count <= count + 8'd1;
    end

endmodule

// File: rtl/score_ctrl.sv
// Pong rule controller: detects goals per frame, drives score digit pulses, and
// sequences serve delay, point handling and game over.
module score_ctrl
    import score_ctrl_pkg::*;
#(
    parameter logic [9:0] GOAL_LX      = GOAL_LX_DEF,
    parameter logic [9:0] GOAL_RX      = GOAL_RX_DEF,
    parameter logic [3:0] WIN_SCORE    = 4'd9,
    parameter logic [7:0] SERVE_FRAMES = 8'd60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [9:0] ball_x,
    input  logic       start,
    output logic       inc_left,
    output logic       inc_right,
    output logic       score_reset,
    output logic       serve,
    output logic       serve_dir,
    output logic       ball_freeze,
    output logic       game_over,
    output logic [3:0] score_left,
    output logic [3:0] score_right
);

    state_t     state, state_nx;
    logic       inc_left_nx, inc_right_nx, score_reset_nx, serve_nx, serve_dir_nx;
    logic [3:0] score_left_nx, score_right_nx;
    logic       timer_done;
    logic       right_scores, left_scores;

    assign right_scores = (ball_x <= GOAL_LX);
    assign left_scores  = (ball_x >= GOAL_RX);

    // Timer is held clear outside SERVE, so it starts from zero on every entry.
    serve_timer #(.SERVE_FRAMES(SERVE_FRAMES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != ST_SERVE),
        .tick (frame_tick),
        .done (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            inc_left    <= 1'b0;
            inc_right   <= 1'b0;
            score_reset <= 1'b0;
            serve       <= 1'b0;
            serve_dir   <= 1'b0;
            score_left  <= 4'd0;
            score_right <= 4'd0;
        end else begin
            state       <= state_nx;
            inc_left    <= inc_left_nx;
            inc_right   <= inc_right_nx;
            score_reset <= score_reset_nx;
            serve       <= serve_nx;
            serve_dir   <= serve_dir_nx;
            score_left  <= score_left_nx;
            score_right <= score_right_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_OVER: if (start) state_nx = ST_SERVE;
            ST_SERVE:         if (timer_done) state_nx = ST_PLAY;
            ST_PLAY:          if (frame_tick && (right_scores || left_scores)) state_nx = ST_POINT;
            ST_POINT:         state_nx = (score_left == WIN_SCORE || score_right == WIN_SCORE)
                                         ? ST_OVER : ST_SERVE;
            default:          state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        inc_left_nx    = 1'b0;
        inc_right_nx   = 1'b0;
        score_reset_nx = 1'b0;
        serve_nx       = 1'b0;
        serve_dir_nx   = serve_dir;
        score_left_nx  = score_left;
        score_right_nx = score_right;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    score_reset_nx = 1'b1;
                    score_left_nx  = 4'd0;
                    score_right_nx = 4'd0;
                end
            end
            ST_SERVE: serve_nx = timer_done;
            ST_PLAY: begin
                // Next serve goes toward the side that conceded.
                if (frame_tick && right_scores) begin
                    inc_right_nx   = 1'b1;
                    score_right_nx = sat_inc(score_right, WIN_SCORE);
                    serve_dir_nx   = 1'b0;
                end else if (frame_tick && left_scores) begin
                    inc_left_nx    = 1'b1;
                    score_left_nx  = sat_inc(score_left, WIN_SCORE);
                    serve_dir_nx   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ball_freeze = (state != ST_PLAY);
    assign game_over   = (state == ST_OVER);

endmodule
